// File: rtl/hpu_task_dispatcher_pkg.sv
// Shared types and the round-robin search helper for the HPU task dispatcher.
// Descriptor layouts are defined here so the scheduler and the frontends share one definition.
package hpu_dispatch_pkg;

    localparam int unsigned MaxHpus = 64;

    typedef enum logic {
        Empty = 1'b0,
        Full  = 1'b1
    } dispatch_state_e;

    typedef struct packed {
        logic [31:0] handler_fun;
        logic [15:0] msgid;
        logic [31:0] pkt_ptr;
    } hpu_handler_task_t;

    typedef struct packed {
        logic [15:0] msgid;
        logic [31:0] pkt_ptr;
    } task_feedback_descr_t;

    typedef struct packed {
        logic       found;
        logic [5:0] idx;
    } rr_pick_t;

    // Scans num entries of mask starting at ptr, wrapping at num; returns the first set index.
    function automatic rr_pick_t rr_next_eligible(input logic [MaxHpus-1:0] mask,
                                                  input int unsigned ptr,
                                                  input int unsigned num);
        rr_pick_t    pick;
        int unsigned cand;
        logic [5:0]  cand_idx;
        pick = '0;
        for (int unsigned k = 0; k < MaxHpus; k++) begin
            cand = ptr + k;
            if (cand >= num) cand = cand - num;
            cand_idx = 6'(cand);
            if (k < num && !pick.found && mask[cand_idx]) begin
                pick.found = 1'b1;
                pick.idx   = cand_idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/hpu_task_dispatcher_if.sv
// Scheduler-side and HPU-side task/feedback streams of the dispatcher.
// master = dispatcher view, slave = scheduler plus frontends view.
interface hpu_task_dispatcher_if
    import hpu_dispatch_pkg::*;
#(
    parameter int unsigned NUM_HPUS = 8
);
    logic                                        task_valid_i;
    logic                                        task_ready_o;
    hpu_handler_task_t                           task_i;
    logic                 [NUM_HPUS-1:0]         hpu_active_i;
    logic                 [NUM_HPUS-1:0]         hpu_task_valid_o;
    logic                 [NUM_HPUS-1:0]         hpu_task_ready_i;
    hpu_handler_task_t                           hpu_task_o;
    logic                 [NUM_HPUS-1:0]         hpu_feedback_valid_i;
    logic                 [NUM_HPUS-1:0]         hpu_feedback_ready_o;
    task_feedback_descr_t [NUM_HPUS-1:0]         hpu_feedback_i;
    logic                                        feedback_valid_o;
    logic                                        feedback_ready_i;
    task_feedback_descr_t                        feedback_o;

    modport master (
        input  task_valid_i, task_i, hpu_active_i, hpu_task_ready_i,
               hpu_feedback_valid_i, hpu_feedback_i, feedback_ready_i,
        output task_ready_o, hpu_task_valid_o, hpu_task_o,
               hpu_feedback_ready_o, feedback_valid_o, feedback_o
    );

    modport slave (
        output task_valid_i, task_i, hpu_active_i, hpu_task_ready_i,
               hpu_feedback_valid_i, hpu_feedback_i, feedback_ready_i,
        input  task_ready_o, hpu_task_valid_o, hpu_task_o,
               hpu_feedback_ready_o, feedback_valid_o, feedback_o
    );
endinterface

// File: rtl/hpu_task_dispatcher_rr.sv
// Round-robin picker: first requester at or after the pointer; once offered with i_enable
// the choice is held until i_ack, which also moves the pointer just past the winner.
module hpu_rr_select
    import hpu_dispatch_pkg::*;
#(
    parameter  int unsigned NUM_HPUS = 8,
    localparam int unsigned IdxWidth = $clog2(NUM_HPUS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_HPUS-1:0] i_req,
    input  logic                i_enable,
    input  logic                i_ack,
    output logic                o_valid,
    output logic [IdxWidth-1:0] o_idx
);
    logic [IdxWidth-1:0] r_ptr;
    logic [IdxWidth-1:0] r_lock_idx;
    logic                r_locked;
    rr_pick_t            w_pick;

    always_comb begin
        w_pick  = rr_next_eligible(MaxHpus'(i_req), 32'(r_ptr), NUM_HPUS);
        o_valid = w_pick.found;
        o_idx   = IdxWidth'(w_pick.idx);
        if (r_locked) begin
            o_valid = 1'b1;
            o_idx   = r_lock_idx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr      <= '0;
            r_lock_idx <= '0;
            r_locked   <= 1'b0;
        end else if (i_ack) begin
            r_locked <= 1'b0;
            r_ptr    <= (o_idx == IdxWidth'(NUM_HPUS - 1)) ? '0 : o_idx + 1'b1;
        end else if (o_valid && i_enable) begin
            r_locked   <= 1'b1;
            r_lock_idx <= o_idx;
        end
    end
endmodule

// File: rtl/hpu_task_dispatcher.sv
// Dispatches scheduler tasks to idle active HPU frontends and merges their feedback.
// Optional statistics counter on tasks_dispatched_o is built when HPU_DISPATCH_STATS_EN is defined.
module hpu_task_dispatcher
    import hpu_dispatch_pkg::*;
#(
    parameter  int unsigned NUM_HPUS = 8,
    localparam int unsigned IdxWidth = $clog2(NUM_HPUS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    hpu_task_dispatcher_if.master bus,
    output logic [NUM_HPUS-1:0]   busy_o,
    output logic [IdxWidth:0]     num_busy_o,
    output logic [31:0]           tasks_dispatched_o,
    output dispatch_state_e       dbg_state_o
);
    // Every stream transfers on a cycle where valid && ready; valid never waits on ready,
    // and an offered payload and target stay stable until that transfer.
    dispatch_state_e      r_state, w_state_next;
    hpu_handler_task_t    r_task;
    logic [NUM_HPUS-1:0]  r_busy;
    logic [IdxWidth:0]    r_num_busy;
    logic                 r_fb_valid;
    task_feedback_descr_t r_fb;

    logic [NUM_HPUS-1:0]  w_eligible, w_task_onehot, w_fb_onehot;
    logic [NUM_HPUS-1:0]  w_busy_set, w_busy_clr, w_busy_next;
    logic [IdxWidth-1:0]  w_task_idx, w_fb_idx;
    logic                 w_task_sel_valid, w_fb_sel_valid;
    logic                 w_dispatch_hs, w_task_load, w_fb_hs, w_fb_can_accept;

    assign w_eligible = bus.hpu_active_i & ~r_busy;

    hpu_rr_select #(.NUM_HPUS(NUM_HPUS)) u_task_rr (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_req    (w_eligible),
        .i_enable (r_state == Full),
        .i_ack    (w_dispatch_hs),
        .o_valid  (w_task_sel_valid),
        .o_idx    (w_task_idx)
    );

    assign w_task_onehot        = w_task_sel_valid ? (NUM_HPUS'(1) << w_task_idx) : '0;
    assign bus.hpu_task_valid_o = (r_state == Full) ? w_task_onehot : '0;
    assign bus.hpu_task_o       = r_task;
    assign w_dispatch_hs        = |(bus.hpu_task_valid_o & bus.hpu_task_ready_i);

    always_comb begin
        w_state_next     = r_state;
        bus.task_ready_o = 1'b0;
        case (r_state)
            Empty: begin
                bus.task_ready_o = 1'b1;
                if (bus.task_valid_i) w_state_next = Full;
            end
            Full: begin
                bus.task_ready_o = w_dispatch_hs;
                if (w_dispatch_hs && !bus.task_valid_i) w_state_next = Empty;
            end
            default: w_state_next = Empty;
        endcase
    end

    assign w_task_load = bus.task_valid_i && bus.task_ready_o;

    // The single-entry feedback buffer accepts whenever it is empty or being drained.
    assign w_fb_can_accept = !r_fb_valid || bus.feedback_ready_i;

    hpu_rr_select #(.NUM_HPUS(NUM_HPUS)) u_fb_rr (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_req    (bus.hpu_feedback_valid_i),
        .i_enable (w_fb_can_accept),
        .i_ack    (w_fb_hs),
        .o_valid  (w_fb_sel_valid),
        .o_idx    (w_fb_idx)
    );

    assign w_fb_onehot              = w_fb_sel_valid ? (NUM_HPUS'(1) << w_fb_idx) : '0;
    assign bus.hpu_feedback_ready_o = w_fb_can_accept ? w_fb_onehot : '0;
    assign w_fb_hs                  = |(bus.hpu_feedback_ready_o & bus.hpu_feedback_valid_i);
    assign bus.feedback_valid_o     = r_fb_valid;
    assign bus.feedback_o           = r_fb;

    assign w_busy_set  = w_dispatch_hs ? bus.hpu_task_valid_o : '0;
    assign w_busy_clr  = w_fb_hs ? bus.hpu_feedback_ready_o : '0;
    assign w_busy_next = (r_busy & ~w_busy_clr) | w_busy_set;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= Empty;
            r_task     <= '0;
            r_busy     <= '0;
            r_num_busy <= '0;
            r_fb_valid <= 1'b0;
            r_fb       <= '0;
        end else begin
            r_state    <= w_state_next;
            r_busy     <= w_busy_next;
            r_num_busy <= (IdxWidth + 1)'($countones(w_busy_next));
            if (w_task_load) r_task <= bus.task_i;
            if (w_fb_hs) begin
                r_fb_valid <= 1'b1;
                r_fb       <= bus.hpu_feedback_i[w_fb_idx];
            end else if (bus.feedback_ready_i) begin
                r_fb_valid <= 1'b0;
            end
        end
    end

    assign busy_o      = r_busy;
    assign num_busy_o  = r_num_busy;
    assign dbg_state_o = r_state;

`ifdef HPU_DISPATCH_STATS_EN
    logic [31:0] r_tasks_dispatched;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)            r_tasks_dispatched <= '0;
        else if (w_dispatch_hs) r_tasks_dispatched <= r_tasks_dispatched + 32'd1;
    end
    assign tasks_dispatched_o = r_tasks_dispatched;
`else
    assign tasks_dispatched_o = '0;
`endif
endmodule

// File: tb/tb_hpu_task_dispatcher.sv
// Directed bench for hpu_task_dispatcher: dispatch order, stalls, feedback arbitration,
// backpressure and asynchronous reset, with hand-computed expectations.
module tb_hpu_task_dispatcher;
    import hpu_dispatch_pkg::*;

`ifdef HPU_DISPATCH_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  busy;
    logic [3:0]  num_busy;
    logic [31:0] stats;
    dispatch_state_e dbg_state;
    int n_checks;
    int n_errors;

    hpu_task_dispatcher_if #(.NUM_HPUS(8)) bus ();

    hpu_task_dispatcher #(.NUM_HPUS(8)) u_dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .bus                (bus),
        .busy_o             (busy),
        .num_busy_o         (num_busy),
        .tasks_dispatched_o (stats),
        .dbg_state_o        (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic hpu_handler_task_t mk_task(input int i);
        hpu_handler_task_t t;
        t.handler_fun = 32'h0000_0100 + 32'(i);
        t.msgid       = 16'h0010 + 16'(i);
        t.pkt_ptr     = 32'h8000_0000 + 32'(i * 64);
        return t;
    endfunction

    function automatic task_feedback_descr_t mk_fb(input int i);
        task_feedback_descr_t f;
        f.msgid   = 16'hA000 + 16'(i);
        f.pkt_ptr = 32'hC000_0000 + 32'(i * 16);
        return f;
    endfunction

    function automatic logic [31:0] exp_stats(input int n);
        return StatsEn ? 32'(n) : 32'd0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n                    = 1'b0;
        bus.task_valid_i         = 1'b0;
        bus.task_i               = '0;
        bus.hpu_active_i         = '0;
        bus.hpu_task_ready_i     = '0;
        bus.hpu_feedback_valid_i = '0;
        bus.hpu_feedback_i       = '0;
        bus.feedback_ready_i     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (bus.task_ready_o !== 1'b1 || dbg_state !== Empty) begin
            n_errors++;
            $display("FAIL reset_ready: ready=%b state=%0d, want ready=1 state=0", bus.task_ready_o, dbg_state);
        end
        n_checks++;
        if (bus.hpu_task_valid_o !== 8'h00 || bus.hpu_feedback_ready_o !== 8'h00 || bus.feedback_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_valids: task_v=%h fb_rdy=%h fb_v=%b, want 00 00 0",
                     bus.hpu_task_valid_o, bus.hpu_feedback_ready_o, bus.feedback_valid_o);
        end
        n_checks++;
        if (busy !== 8'h00 || num_busy !== 4'd0 || stats !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_status: busy=%h num=%0d stats=%0d, want 00 0 0", busy, num_busy, stats);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_v;
        logic [7:0] exp_b;
        do_reset();
        bus.hpu_active_i     = 8'hFF;
        bus.hpu_task_ready_i = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            bus.task_valid_i = (i < 4);
            bus.task_i       = mk_task(i);
            #1;
            exp_v = (i >= 1 && i <= 4) ? (8'h01 << (i - 1)) : 8'h00;
            exp_b = (i <= 1) ? 8'h00 : ((8'h01 << (i - 1)) - 8'h01);
            n_checks++;
            if (bus.hpu_task_valid_o !== exp_v || busy !== exp_b || bus.task_ready_o !== 1'b1) begin
                n_errors++;
                $display("FAIL b2b_cycle%0d: valid=%h busy=%h ready=%b, want %h %h 1",
                         i, bus.hpu_task_valid_o, busy, bus.task_ready_o, exp_v, exp_b);
            end
            if (i >= 1 && i <= 4) begin
                n_checks++;
                if (bus.hpu_task_o !== mk_task(i - 1)) begin
                    n_errors++;
                    $display("FAIL b2b_payload%0d: got %h want %h", i, bus.hpu_task_o, mk_task(i - 1));
                end
            end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (busy !== 8'h0F || num_busy !== 4'd4 || stats !== exp_stats(4)) begin
            n_errors++;
            $display("FAIL b2b_final: busy=%h num=%0d stats=%0d, want 0f 4 %0d", busy, num_busy, stats, exp_stats(4));
        end
    endtask

    task automatic test_inactive();
        do_reset();
        bus.hpu_task_ready_i = 8'hFF;
        bus.task_valid_i     = 1'b1;
        bus.task_i           = mk_task(10);
        @(negedge clk);
        bus.task_i = mk_task(11);
        #1;
        n_checks++;
        if (bus.hpu_task_valid_o !== 8'h00 || bus.task_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL inactive_stall: valid=%h ready=%b, want 00 0", bus.hpu_task_valid_o, bus.task_ready_o);
        end
        repeat (2) @(negedge clk);
        bus.hpu_active_i = 8'h20;
        #1;
        n_checks++;
        if (bus.hpu_task_valid_o !== 8'h20 || bus.hpu_task_o !== mk_task(10) || bus.task_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL inactive_raise5: valid=%h task=%h ready=%b, want 20 %h 1",
                     bus.hpu_task_valid_o, bus.hpu_task_o, bus.task_ready_o, mk_task(10));
        end
        @(negedge clk);
        bus.task_valid_i = 1'b0;
        #1;
        n_checks++;
        if (busy !== 8'h20 || bus.hpu_task_valid_o !== 8'h00 || dbg_state !== Full || bus.task_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL inactive_after: busy=%h valid=%h state=%0d ready=%b, want 20 00 1 0",
                     busy, bus.hpu_task_valid_o, dbg_state, bus.task_ready_o);
        end
    endtask

    task automatic test_stall_release();
        do_reset();
        bus.hpu_active_i     = 8'hFF;
        bus.hpu_task_ready_i = 8'hFF;
        bus.feedback_ready_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.task_valid_i = 1'b1;
            bus.task_i       = mk_task(20 + i);
            @(negedge clk);
        end
        bus.task_valid_i = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 8'hFF || num_busy !== 4'd8 || bus.hpu_task_valid_o !== 8'h00 || bus.task_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_full: busy=%h num=%0d valid=%h ready=%b, want ff 8 00 0",
                     busy, num_busy, bus.hpu_task_valid_o, bus.task_ready_o);
        end
        @(negedge clk);
        bus.hpu_feedback_valid_i = 8'h08;
        bus.hpu_feedback_i[3]    = mk_fb(3);
        #1;
        n_checks++;
        if (bus.hpu_feedback_ready_o !== 8'h08 || bus.hpu_task_valid_o !== 8'h00) begin
            n_errors++;
            $display("FAIL stall_fb3: fb_rdy=%h valid=%h, want 08 00", bus.hpu_feedback_ready_o, bus.hpu_task_valid_o);
        end
        @(negedge clk);
        bus.hpu_feedback_valid_i = 8'h00;
        #1;
        n_checks++;
        if (busy !== 8'hF7 || bus.hpu_task_valid_o !== 8'h08 || bus.hpu_task_o !== mk_task(28)) begin
            n_errors++;
            $display("FAIL stall_redispatch: busy=%h valid=%h task=%h, want f7 08 %h",
                     busy, bus.hpu_task_valid_o, bus.hpu_task_o, mk_task(28));
        end
        n_checks++;
        if (bus.feedback_valid_o !== 1'b1 || bus.feedback_o !== mk_fb(3)) begin
            n_errors++;
            $display("FAIL stall_fbout: v=%b fb=%h, want 1 %h", bus.feedback_valid_o, bus.feedback_o, mk_fb(3));
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 8'hFF || num_busy !== 4'd8 || bus.task_ready_o !== 1'b1 || bus.feedback_valid_o !== 1'b0
            || stats !== exp_stats(9)) begin
            n_errors++;
            $display("FAIL stall_end: busy=%h num=%0d ready=%b fb_v=%b stats=%0d, want ff 8 1 0 %0d",
                     busy, num_busy, bus.task_ready_o, bus.feedback_valid_o, stats, exp_stats(9));
        end
    endtask

    task automatic test_fb_arbitration();
        do_reset();
        bus.feedback_ready_i = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            bus.hpu_feedback_valid_i = 8'h44;
            bus.hpu_feedback_i[2]    = mk_fb(40 + 2 * rep);
            bus.hpu_feedback_i[6]    = mk_fb(41 + 2 * rep);
            #1;
            n_checks++;
            if (bus.hpu_feedback_ready_o !== 8'h04) begin
                n_errors++;
                $display("FAIL arb_first%0d: fb_rdy=%h want 04", rep, bus.hpu_feedback_ready_o);
            end
            @(negedge clk);
            bus.hpu_feedback_valid_i = 8'h40;
            #1;
            n_checks++;
            if (bus.hpu_feedback_ready_o !== 8'h40 || bus.feedback_valid_o !== 1'b1
                || bus.feedback_o !== mk_fb(40 + 2 * rep)) begin
                n_errors++;
                $display("FAIL arb_out2_%0d: fb_rdy=%h v=%b fb=%h, want 40 1 %h",
                         rep, bus.hpu_feedback_ready_o, bus.feedback_valid_o, bus.feedback_o, mk_fb(40 + 2 * rep));
            end
            @(negedge clk);
            bus.hpu_feedback_valid_i = 8'h00;
            #1;
            n_checks++;
            if (bus.feedback_valid_o !== 1'b1 || bus.feedback_o !== mk_fb(41 + 2 * rep) || busy !== 8'h00) begin
                n_errors++;
                $display("FAIL arb_out6_%0d: v=%b fb=%h busy=%h, want 1 %h 00",
                         rep, bus.feedback_valid_o, bus.feedback_o, busy, mk_fb(41 + 2 * rep));
            end
            @(negedge clk);
            #1;
            n_checks++;
            if (bus.feedback_valid_o !== 1'b0) begin
                n_errors++;
                $display("FAIL arb_drain%0d: v=%b want 0", rep, bus.feedback_valid_o);
            end
        end
    endtask

    task automatic test_fb_backpressure();
        do_reset();
        bus.hpu_active_i     = 8'hFF;
        bus.hpu_task_ready_i = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            bus.task_valid_i = (i < 3);
            bus.task_i       = mk_task(60 + i);
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) bus.hpu_feedback_i[k] = mk_fb(50 + k);
        bus.hpu_feedback_valid_i = 8'h07;
        #1;
        n_checks++;
        if (bus.hpu_feedback_ready_o !== 8'h01 || busy !== 8'h07) begin
            n_errors++;
            $display("FAIL bp_start: fb_rdy=%h busy=%h, want 01 07", bus.hpu_feedback_ready_o, busy);
        end
        @(negedge clk);
        bus.hpu_feedback_valid_i = 8'h06;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_checks++;
            if (bus.hpu_feedback_ready_o !== 8'h00 || busy !== 8'h06 || bus.feedback_valid_o !== 1'b1
                || bus.feedback_o !== mk_fb(50)) begin
                n_errors++;
                $display("FAIL bp_hold%0d: fb_rdy=%h busy=%h v=%b fb=%h, want 00 06 1 %h",
                         c, bus.hpu_feedback_ready_o, busy, bus.feedback_valid_o, bus.feedback_o, mk_fb(50));
            end
            @(negedge clk);
        end
        bus.feedback_ready_i = 1'b1;
        #1;
        n_checks++;
        if (bus.hpu_feedback_ready_o !== 8'h02) begin
            n_errors++;
            $display("FAIL bp_pop_push: fb_rdy=%h want 02", bus.hpu_feedback_ready_o);
        end
        @(negedge clk);
        bus.hpu_feedback_valid_i = 8'h04;
        #1;
        n_checks++;
        if (bus.feedback_o !== mk_fb(51) || busy !== 8'h04 || bus.hpu_feedback_ready_o !== 8'h04) begin
            n_errors++;
            $display("FAIL bp_next: fb=%h busy=%h fb_rdy=%h, want %h 04 04",
                     bus.feedback_o, busy, bus.hpu_feedback_ready_o, mk_fb(51));
        end
        @(negedge clk);
        bus.hpu_feedback_valid_i = 8'h00;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.hpu_active_i     = 8'hFF;
        bus.hpu_task_ready_i = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            bus.task_valid_i = 1'b1;
            bus.task_i       = mk_task(70 + i);
            @(negedge clk);
        end
        bus.task_valid_i     = 1'b0;
        bus.hpu_task_ready_i = 8'h00;
        #1;
        n_checks++;
        if (busy !== 8'h03 || bus.hpu_task_valid_o !== 8'h04 || dbg_state !== Full || stats !== exp_stats(2)) begin
            n_errors++;
            $display("FAIL rstmid_pre: busy=%h valid=%h state=%0d stats=%0d, want 03 04 1 %0d",
                     busy, bus.hpu_task_valid_o, dbg_state, stats, exp_stats(2));
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 8'h00 || num_busy !== 4'd0 || bus.hpu_task_valid_o !== 8'h00 || bus.feedback_valid_o !== 1'b0
            || bus.task_ready_o !== 1'b1 || stats !== 32'd0 || dbg_state !== Empty) begin
            n_errors++;
            $display("FAIL rstmid_async: busy=%h num=%0d valid=%h fb_v=%b ready=%b stats=%0d state=%0d",
                     busy, num_busy, bus.hpu_task_valid_o, bus.feedback_valid_o, bus.task_ready_o, stats, dbg_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        test_reset();
        test_back_to_back();
        test_inactive();
        test_stall_release();
        test_fb_arbitration();
        test_fb_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/hpu_task_dispatcher.md
Name: hpu_task_dispatcher

Overview:
- Initiator side of the HPU task/feedback interface.
- Accepts handler tasks from the cluster scheduler and dispatches each to exactly one idle, active HPU frontend.
- Tracks per-HPU busy state; merges the per-HPU feedback streams into one feedback stream back to the scheduler.
- One instance per cluster, between the cluster scheduler and the NUM_HPUS task frontends.

Parameters:
- NUM_HPUS, 8, number of attached HPU frontends (≥2)
- hpu_handler_task_t, logic, task descriptor type (contains handler_task.handler_fun, msgid, pkt_ptr)
- task_feedback_descr_t, logic, feedback descriptor type
- IdxWidth, $clog2(NUM_HPUS), derived, not overridable

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- task_valid_i  in  1  scheduler task valid
- task_ready_o  out  1  scheduler task ready
- task_i  in  hpu_handler_task_t  task descriptor
- hpu_active_i  in  NUM_HPUS  frontend has left Init
- hpu_task_valid_o  out  NUM_HPUS  per-HPU task valid, one-hot or zero
- hpu_task_ready_i  in  NUM_HPUS  per-HPU task ready
- hpu_task_o  out  hpu_handler_task_t  task payload, broadcast to all HPUs
- hpu_feedback_valid_i  in  NUM_HPUS  per-HPU feedback valid
- hpu_feedback_ready_o  out  NUM_HPUS  per-HPU feedback ready, one-hot or zero
- hpu_feedback_i  in  NUM_HPUS x task_feedback_descr_t  per-HPU feedback
- feedback_valid_o  out  1  merged feedback valid
- feedback_ready_i  in  1  merged feedback ready
- feedback_o  out  task_feedback_descr_t  merged feedback
- busy_o  out  NUM_HPUS  per-HPU busy bitmap
- num_busy_o  out  IdxWidth+1  popcount of busy_o
- tasks_dispatched_o  out  32  statistics counter (see Optional Feature)

Behaviour:
- Reset values: every output valid = 0; busy_o = 0; num_busy_o = 0; holding register = Empty; both round-robin pointers = 0; tasks_dispatched_o = 0.
- task_ready_o = 1 after reset.
- Task path FSM, states Empty and Full:
  - Empty: task_ready_o = 1. A handshake latches task_i and moves to Full.
  - Full: an HPU i is eligible when hpu_active_i[i] && !busy_q[i].
  - Round-robin select starts at rr_task_q and picks the first eligible i. Drive hpu_task_valid_o[i] = 1; all other bits 0. Hold the selection stable until the handshake.
  - If no HPU is eligible, all hpu_task_valid_o bits = 0.
  - On hpu_task_ready_i[i]: set busy_q[i] (visible next cycle), set rr_task_q = i+1 (mod NUM_HPUS), pulse the statistics increment.
  - task_ready_o = 1 in Full only in a cycle with a dispatch handshake. A new task is then latched and the state stays Full, giving back-to-back throughput of 1 task/cycle.
- Latency: a task accepted in cycle t is presented to an HPU no earlier than cycle t+1.
- A dispatched HPU never receives a second task until its feedback has been handshaken.
- Feedback path:
  - Round-robin arbiter over hpu_feedback_valid_i, pointer rr_fb_q.
  - Winner w gets hpu_feedback_ready_o[w] = 1 only when the output buffer can accept.
  - The handshake clears busy_q[w] (visible next cycle) and pushes hpu_feedback_i[w] into a depth-1 non-fall-through buffer. feedback_valid_o appears at t+1.
  - Full throughput requires the buffer to accept while popping.
- Feedback arriving from a non-busy HPU (including handler_fun==0 tasks that complete instantly) is forwarded normally; the busy clear is a no-op.
- Same-cycle events:
  - Dispatch to HPU i and feedback from HPU j≠i in the same cycle: both take effect.
  - Feedback from i in the same cycle as eligibility evaluation: i is not eligible until the next cycle.
- hpu_active_i[i] falling while busy_q[i] = 1: busy is retained until feedback arrives.
- num_busy_o is registered together with busy_q (same cycle).
- Asynchronous reset mid-operation discards the held task and the buffered feedback; no output glitch beyond the reset values.

Optional Feature:
- Macro: HPU_DISPATCH_STATS_EN.
- Defined: tasks_dispatched_o is a 32-bit counter, +1 per dispatch handshake, wraps 0xFFFFFFFF→0.
- Undefined: tasks_dispatched_o tied to 0 and no counter flops are synthesized.

Decomposition:
- Package hpu_dispatch_pkg holds the dispatch_state_e enum (Empty, Full) and a rr_next_eligible function (mask plus pointer to index plus found flag).
- The feedback buffer is a stream_fifo (DEPTH 1, FALL_THROUGH 0).
- One natural sub-module: hpu_rr_select (NUM_HPUS-wide round-robin picker with pointer update). It is instantiated twice, once for tasks and once for feedback.

Test Plan:
- All 8 active, 4 tasks pushed back-to-back, all HPUs always ready → dispatched to HPUs 0,1,2,3 in consecutive cycles; busy_o = 0x0F; num_busy_o = 4.
- hpu_active_i = 0x00, task pushed → no hpu_task_valid_o, task_ready_o = 0 after the first task. Raise bit 5 → dispatch to HPU 5 on the next cycle.
- All busy = 0xFF, 9th task held → stalls. Feedback from HPU 3 accepted at t → busy[3] clears at t+1, task dispatched to HPU 3 at t+1.
- HPUs 2 and 6 assert feedback simultaneously, feedback_ready_i = 1 → outputs HPU 2 then HPU 6 on consecutive cycles. Repeat → order rotates to 6 then 2 only if the pointer passed 2.
- feedback_ready_i = 0 for 10 cycles with 3 pending → exactly one buffered, hpu_feedback_ready_o = 0, busy bits of the unaccepted HPUs stay set.
- Reset asserted while Full with busy = 0x3 → busy_o = 0, all valids = 0 immediately, tasks_dispatched_o = 0.
